// File: rtl/pipelined_control_unit_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the pipelined MIPS control unit: opcode and funct
// codes, bit positions inside the memory and write-back control fields, the
// pc_src / reg_dest encodings, the halt state machine encoding and the
// control bundle that travels from ID into the ID/EX register.
// No ports (package).
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

  // Primary opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_LWU   = 6'b100111;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_NOP   = 6'b111110;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // R-type funct codes that change control flow
  localparam logic [5:0] FUNCT_JR   = 6'b001000;
  localparam logic [5:0] FUNCT_JALR = 6'b001001;

  // Bit positions inside mem_signals
  localparam int MEM_SIGN  = 5;
  localparam int MEM_READ  = 4;
  localparam int MEM_WRITE = 3;
  localparam int MEM_WORD  = 2;
  localparam int MEM_HALF  = 1;
  localparam int MEM_BYTE  = 0;

  // Access size one-hot values for mem_signals[2:0]
  localparam logic [2:0] SIZE_WORD = 3'b100;
  localparam logic [2:0] SIZE_HALF = 3'b010;
  localparam logic [2:0] SIZE_BYTE = 3'b001;

  // Write-back field: [2] reg_write, [1:0] result source
  localparam int         WB_REG_WRITE = 2;
  localparam logic [1:0] WB_SRC_MEM   = 2'b00;
  localparam logic [1:0] WB_SRC_ALU   = 2'b01;
  localparam logic [1:0] WB_SRC_PC8   = 2'b10;

  // Next-PC source select
  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REG    = 2'b11;

  // Destination register select
  localparam logic [1:0] REG_DEST_RT  = 2'b00;
  localparam logic [1:0] REG_DEST_RD  = 2'b01;
  localparam logic [1:0] REG_DEST_R31 = 2'b10;

  // Halt drain state machine
  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  // Control bundle produced by the decoder and held in the ID/EX register
  typedef struct packed {
    logic       tipeI;
    logic       beq;
    logic       bne;
    logic       jump;
    logic       jumpReg;
    logic [1:0] pcSrc;
    logic [1:0] regDest;
    logic [5:0] mem;
    logic [2:0] wb;
    logic       illegal;
    logic       halt;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // Builds a mem_signals value from its three flags and the size one-hot
  function automatic logic [5:0] memSig(input logic sign, input logic read,
                                        input logic write, input logic [2:0] size);
    return {sign, read, write, size};
  endfunction

  // Builds a wb_signals value from reg_write and the result source
  function automatic logic [2:0] wbSig(input logic regWrite, input logic [1:0] src);
    return {regWrite, src};
  endfunction

endpackage

// File: rtl/pipelined_control_unit_if.sv
// ---------------------------------------------------------------------------
// pipelined_control_unit_if
// Bundles the IF/ID-side inputs and the ID/EX-side control outputs of the
// pipelined control unit.
//   master : the pipeline around the unit (drives instruction, stall, flush,
//            resume; consumes the registered control bundle)
//   slave  : the control unit itself
// Signals: instr_valid_i, opcode_i, funct_i, stall_i, flush_i, resume_i in;
//          valid_o, tipe_i_o, beq_o, bne_o, jump_o, jump_reg_o, pc_src_o,
//          reg_dest_o, mem_signals_o, wb_signals_o, opcode_o, illegal_o,
//          halt_o, halted_o, pc_write_en_o out.
// ---------------------------------------------------------------------------
interface pipelined_control_unit_if #(
  parameter int NB_OP     = 6,
  parameter int NB_FUNCT  = 6,
  parameter int N_REGDEST = 2
);

  logic                 instr_valid_i;
  logic [NB_OP-1:0]     opcode_i;
  logic [NB_FUNCT-1:0]  funct_i;
  logic                 stall_i;
  logic                 flush_i;
  logic                 resume_i;

  logic                 valid_o;
  logic                 tipe_i_o;
  logic                 beq_o;
  logic                 bne_o;
  logic                 jump_o;
  logic                 jump_reg_o;
  logic [1:0]           pc_src_o;
  logic [N_REGDEST-1:0] reg_dest_o;
  logic [5:0]           mem_signals_o;
  logic [2:0]           wb_signals_o;
  logic [NB_OP-1:0]     opcode_o;
  logic                 illegal_o;
  logic                 halt_o;
  logic                 halted_o;
  logic                 pc_write_en_o;

  modport master (
    output instr_valid_i, opcode_i, funct_i, stall_i, flush_i, resume_i,
    input  valid_o, tipe_i_o, beq_o, bne_o, jump_o, jump_reg_o, pc_src_o,
           reg_dest_o, mem_signals_o, wb_signals_o, opcode_o, illegal_o,
           halt_o, halted_o, pc_write_en_o
  );

  modport slave (
    input  instr_valid_i, opcode_i, funct_i, stall_i, flush_i, resume_i,
    output valid_o, tipe_i_o, beq_o, bne_o, jump_o, jump_reg_o, pc_src_o,
           reg_dest_o, mem_signals_o, wb_signals_o, opcode_o, illegal_o,
           halt_o, halted_o, pc_write_en_o
  );

endinterface

// File: rtl/pipelined_control_unit_decoder.sv
// ---------------------------------------------------------------------------
// main_decoder
// Purely combinational MIPS main decoder: opcode/funct -> control bundle.
// Unknown opcodes produce an all-zero bundle with the illegal flag set.
//   opcode_i : instruction[31:26]
//   funct_i  : instruction[5:0] (only inspected for R-type)
//   ctrl_o   : decoded control bundle
// ---------------------------------------------------------------------------
module main_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int NB_OP    = 6,
  parameter int NB_FUNCT = 6
) (
  input  logic [NB_OP-1:0]    opcode_i,
  input  logic [NB_FUNCT-1:0] funct_i,
  output ctrl_t               ctrl_o
);

  // Start from an all-zero bundle so every field not named by an opcode
  // stays 0 and nothing can ever be left undriven.
  always_comb begin
    ctrl_o = CTRL_BUBBLE;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FUNCT_JR: begin
            ctrl_o.jumpReg = 1'b1;
            ctrl_o.pcSrc   = PC_SRC_REG;
          end
          FUNCT_JALR: begin
            ctrl_o.jumpReg = 1'b1;
            ctrl_o.pcSrc   = PC_SRC_REG;
            ctrl_o.regDest = REG_DEST_RD;
            ctrl_o.wb      = wbSig(1'b1, WB_SRC_PC8);
          end
          default: begin
            ctrl_o.regDest = REG_DEST_RD;
            ctrl_o.wb      = wbSig(1'b1, WB_SRC_ALU);
          end
        endcase
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl_o.tipeI = 1'b1;
        ctrl_o.wb    = wbSig(1'b1, WB_SRC_ALU);
      end
      OP_LW, OP_LH, OP_LB, OP_LHU, OP_LBU, OP_LWU: begin
        ctrl_o.tipeI = 1'b1;
        ctrl_o.wb    = wbSig(1'b1, WB_SRC_MEM);
        case (opcode_i)
          OP_LW:   ctrl_o.mem = memSig(1'b1, 1'b1, 1'b0, SIZE_WORD);
          OP_LH:   ctrl_o.mem = memSig(1'b1, 1'b1, 1'b0, SIZE_HALF);
          OP_LB:   ctrl_o.mem = memSig(1'b1, 1'b1, 1'b0, SIZE_BYTE);
          OP_LHU:  ctrl_o.mem = memSig(1'b0, 1'b1, 1'b0, SIZE_HALF);
          OP_LBU:  ctrl_o.mem = memSig(1'b0, 1'b1, 1'b0, SIZE_BYTE);
          default: ctrl_o.mem = memSig(1'b0, 1'b1, 1'b0, SIZE_WORD);
        endcase
      end
      OP_SW, OP_SH, OP_SB: begin
        ctrl_o.tipeI = 1'b1;
        case (opcode_i)
          OP_SW:   ctrl_o.mem = memSig(1'b0, 1'b0, 1'b1, SIZE_WORD);
          OP_SH:   ctrl_o.mem = memSig(1'b0, 1'b0, 1'b1, SIZE_HALF);
          default: ctrl_o.mem = memSig(1'b0, 1'b0, 1'b1, SIZE_BYTE);
        endcase
      end
      OP_BEQ: begin
        ctrl_o.beq   = 1'b1;
        ctrl_o.pcSrc = PC_SRC_BRANCH;
      end
      OP_BNE: begin
        ctrl_o.bne   = 1'b1;
        ctrl_o.pcSrc = PC_SRC_BRANCH;
      end
      OP_J: begin
        ctrl_o.jump  = 1'b1;
        ctrl_o.pcSrc = PC_SRC_JUMP;
      end
      OP_JAL: begin
        ctrl_o.jump    = 1'b1;
        ctrl_o.pcSrc   = PC_SRC_JUMP;
        ctrl_o.regDest = REG_DEST_R31;
        ctrl_o.wb      = wbSig(1'b1, WB_SRC_PC8);
      end
      OP_NOP: begin
        ctrl_o = CTRL_BUBBLE;
      end
      OP_HALT: begin
        ctrl_o.halt = 1'b1;
      end
      default: begin
        ctrl_o.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// ---------------------------------------------------------------------------
// pipelined_control_unit
// ID-stage control: decodes the IF/ID instruction and registers the control
// bundle into ID/EX, with stall (hold), flush (bubble) and a HALT drain state
// machine that freezes the PC until the instructions ahead have retired.
//   clock, reset : system clock, asynchronous active-high reset
//   bus (slave)  : instruction/hazard inputs and registered control outputs,
//                  plus halted_o and the combinational pc_write_en_o
// ---------------------------------------------------------------------------
module pipelined_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int NB_OP       = 6,
  parameter int NB_FUNCT    = 6,
  parameter int N_REGDEST   = 2,
  parameter int DRAIN_DEPTH = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  pipelined_control_unit_if.slave bus
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_DEPTH - 1);

  ctrl_t            decoded;
  ctrl_t            ctrl_q;
  logic             valid_q;
  logic [NB_OP-1:0] opcode_q;
  state_t           state_q;
  state_t           state_d;
  logic [3:0]       drainCnt_q;
  logic [3:0]       drainCnt_d;
  logic             haltIn;

  main_decoder #(
    .NB_OP    (NB_OP),
    .NB_FUNCT (NB_FUNCT)
  ) u_decoder (
    .opcode_i (bus.opcode_i),
    .funct_i  (bus.funct_i),
    .ctrl_o   (decoded)
  );

  assign haltIn = decoded.halt & bus.instr_valid_i;

  // State register for the halt drain machine and its cycle counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      drainCnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      drainCnt_q <= drainCnt_d;
    end
  end

  // Next-state logic. Only a HALT that actually lands in the stage register
  // (not stalled, not flushed) starts the drain; once draining, flushes have
  // no effect on the countdown.
  always_comb begin
    state_d    = state_q;
    drainCnt_d = drainCnt_q;
    case (state_q)
      ST_RUN: begin
        if (!bus.flush_i && !bus.stall_i && haltIn) begin
          state_d    = ST_DRAIN;
          drainCnt_d = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (drainCnt_q == 4'd0) begin
          state_d = ST_HALTED;
        end else begin
          drainCnt_d = drainCnt_q - 4'd1;
        end
      end
      ST_HALTED: begin
        if (bus.resume_i) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d    = ST_RUN;
        drainCnt_d = 4'd0;
      end
    endcase
  end

  // FSM outputs. The PC is frozen as soon as a valid HALT is sitting in ID so
  // nothing behind it is fetched, and stays frozen until resumed.
  always_comb begin
    bus.halted_o      = (state_q == ST_HALTED);
    bus.pc_write_en_o = (state_q == ST_RUN) && !bus.stall_i && !haltIn;
  end

  // ID/EX stage register. Flush and any non-RUN state insert a bubble ahead
  // of the stall hold; an empty IF/ID slot also loads a bubble so no stale
  // decode of a meaningless opcode reaches EX.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_q   <= CTRL_BUBBLE;
      valid_q  <= 1'b0;
      opcode_q <= '0;
    end else if (bus.flush_i || (state_q != ST_RUN)) begin
      ctrl_q   <= CTRL_BUBBLE;
      valid_q  <= 1'b0;
      opcode_q <= '0;
    end else if (!bus.stall_i) begin
      if (bus.instr_valid_i) begin
        ctrl_q   <= decoded;
        valid_q  <= 1'b1;
        opcode_q <= bus.opcode_i;
      end else begin
        ctrl_q   <= CTRL_BUBBLE;
        valid_q  <= 1'b0;
        opcode_q <= '0;
      end
    end
  end

  assign bus.valid_o       = valid_q;
  assign bus.tipe_i_o      = ctrl_q.tipeI;
  assign bus.beq_o         = ctrl_q.beq;
  assign bus.bne_o         = ctrl_q.bne;
  assign bus.jump_o        = ctrl_q.jump;
  assign bus.jump_reg_o    = ctrl_q.jumpReg;
  assign bus.pc_src_o      = ctrl_q.pcSrc;
  assign bus.reg_dest_o    = N_REGDEST'(ctrl_q.regDest);
  assign bus.mem_signals_o = ctrl_q.mem;
  assign bus.wb_signals_o  = ctrl_q.wb;
  assign bus.opcode_o      = opcode_q;
  assign bus.illegal_o     = ctrl_q.illegal;
  assign bus.halt_o        = ctrl_q.halt;

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Next-generation MIPS main decoder. Decodes opcode/funct in ID and registers the resulting control bundle into the ID/EX stage.
- Adds stall (hold) and flush (bubble) handling, illegal-opcode flagging, JR/JALR support, and a HALT drain state machine that freezes the PC until the pipeline has retired.
- Sits between the IF/ID register and the EX stage. Feeds the hazard unit and the PC mux.

Parameters:
- NB_OP, 6, opcode width
- NB_FUNCT, 6, funct width
- N_REGDEST, 2, register-destination select width
- DRAIN_DEPTH, 3, cycles to drain after HALT (EX, MEM, WB); legal range 1..15

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- instr_valid_i  in  1  IF/ID holds a real instruction
- opcode_i  in  NB_OP  instruction[31:26]
- funct_i  in  NB_FUNCT  instruction[5:0]
- stall_i  in  1  hazard unit: hold the stage register
- flush_i  in  1  branch taken or exception: insert a bubble
- resume_i  in  1  leave HALTED (debug unit)
- valid_o  out  1  stage holds a real instruction
- tipe_i_o  out  1  ALU operand B is the immediate
- beq_o, bne_o, jump_o, jump_reg_o  out  1 each  control-flow class
- pc_src_o  out  2  00 PC+4, 01 branch, 10 jump immediate, 11 register
- reg_dest_o  out  N_REGDEST  00 rt, 01 rd, 10 r31
- mem_signals_o  out  6  [5] sign, [4] read, [3] write, [2:0] one-hot word/half/byte
- wb_signals_o  out  3  [2] reg_write, [1:0] 00 mem, 01 alu, 10 pc+8
- opcode_o  out  NB_OP  registered opcode
- illegal_o  out  1  registered instruction was undecodable
- halt_o  out  1  registered instruction is HALT
- halted_o  out  1  state == HALTED
- pc_write_en_o  out  1  combinational: PC/IF-ID may advance

Behaviour:
- Reset (asynchronous, active-high): all registered outputs 0, state RUN, drain counter 0. pc_write_en_o therefore goes to 1.
- Decode table (combinational). Any field not listed is 0.
  - R-type 000000: reg_dest 01, wb 101.
    - funct 001000 (JR): jump_reg 1, pc_src 11, wb 000.
    - funct 001001 (JALR): jump_reg 1, pc_src 11, reg_dest 01, wb 110.
  - ADDI/SLTI/ANDI/ORI/XORI/LUI (001000/001010/001100/001101/001110/001111): tipe_i 1, wb 101.
  - LW 100011: mem 110100. LH 100001: mem 110010. LB 100000: mem 110001. LHU 100101: mem 010010. LBU 100100: mem 010001. LWU 100111: mem 010100. All loads: tipe_i 1, wb 100.
  - SW 101011: mem 001100. SH 101001: mem 001010. SB 101000: mem 001001. All stores: tipe_i 1, wb 000.
  - BEQ 000100: beq 1, pc_src 01. BNE 000101: bne 1, pc_src 01. Both: tipe_i 0, wb 000.
  - J 000010: jump 1, pc_src 10.
  - JAL 000011: jump 1, pc_src 10, reg_dest 10, wb 110.
  - NOP 111110: all zero, valid kept.
  - HALT 111111: all zero, halt 1.
  - Anything else: all zero, illegal 1.
- No X values are ever driven.
- Stage-register update, per rising edge. Priority: reset > flush_i > DRAIN bubble > stall_i > load.
  - flush_i: bubble (all control 0, valid_o 0, illegal_o 0, halt_o 0).
  - stall_i without flush_i: hold every output.
  - Load: decoded bundle; valid_o = instr_valid_i. If instr_valid_i = 0, the bundle is forced to a bubble.
- State machine RUN / DRAIN / HALTED:
  - RUN -> DRAIN when a valid HALT is loaded (not stalled, not flushed). Counter loads DRAIN_DEPTH-1.
  - DRAIN: stage loads bubbles. Counter decrements each cycle. At counter == 0, go to HALTED.
  - HALTED: bubbles. resume_i -> RUN on the next edge.
  - A HALT that is flushed in the same cycle is discarded; state stays RUN.
  - flush_i during DRAIN does not abort the drain.
- pc_write_en_o = (state == RUN) && !stall_i && !(HALT decoded with instr_valid_i).
- Latency: one cycle from opcode_i to the outputs.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode and funct localparams
  - mem_signals and wb_signals bit positions
  - pc_src and reg_dest encodings
  - state encoding
- One sub-module, main_decoder: purely combinational opcode/funct -> bundle. The top module holds the stage register, the FSM and the counter.

Test Plan:
- Reset mid-DRAIN with DRAIN_DEPTH=3 -> all outputs 0, halted_o 0, pc_write_en_o 1 immediately.
- Stream LW, SW, BEQ, JAL with valid=1 -> mem 110100/001100/000000/000000; wb 100/000/000/110; pc_src 00/00/01/10, each one cycle after input.
- ADDI loaded, then stall_i=1 for 2 cycles with opcode_i changed to SW -> ADDI bundle held 2 cycles, SW appears on the cycle after stall drops.
- stall_i=1 and flush_i=1 together with LW -> bubble (valid_o 0, mem 000000).
- HALT valid -> halt_o 1 for one cycle, pc_write_en_o 0, exactly 3 bubble cycles, then halted_o 1; resume_i -> RUN, pc_write_en_o 1.
- Opcode 010011 and R-type funct 001000 -> illegal_o 1 with bundle 0; JR gives jump_reg 1, pc_src 11, wb 000.
